// File: rtl/seq_divider_64.sv
// seq_divider_64: iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per clock
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (dividend, divisor, is_signed)
//   out_valid / out_ready result handshake (quotient, remainder, div_by_zero)
// A divide by zero follows RISC-V rules: quotient all ones, remainder = raw dividend.
module seq_divider_64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] q_sh, r_part, d_mag, a_mag_in, d_mag_in, q_nx, r_nx;
    logic [WIDTH:0] shifted, trial;
    logic [CW-1:0] cnt;
    logic neg_q, neg_r, start, d_zero;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign start     = in_valid & in_ready;
    assign d_zero    = divisor == '0;
    assign a_mag_in  = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
    assign d_mag_in  = (is_signed & divisor[WIDTH-1]) ? -divisor : divisor;
    // q_sh starts as the dividend magnitude and is shifted out MSB first while
    // quotient bits shift in at the bottom.
    assign shifted = {r_part, q_sh[WIDTH-1]};
    assign trial   = shifted - {1'b0, d_mag};
    // On borrow the shifted value is below the divisor, so it fits in WIDTH bits.
    assign r_nx = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_nx = {q_sh[WIDTH-2:0], ~trial[WIDTH]};
    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        if (start)
            state_nx = d_zero ? DONE : CALC;
        else if (state == CALC && cnt == '0)
            state_nx = DONE;
        else if (state == DONE && out_ready)
            state_nx = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            q_sh        <= '0;
            r_part      <= '0;
            d_mag       <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (start) begin
            q_sh        <= a_mag_in;
            r_part      <= '0;
            d_mag       <= d_mag_in;
            cnt         <= CW'(WIDTH - 1);
            neg_q       <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r       <= is_signed & dividend[WIDTH-1];
            div_by_zero <= d_zero;
            if (d_zero) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (state == CALC) begin
            q_sh   <= q_nx;
            r_part <= r_nx;
            cnt    <= cnt - CW'(1);
            if (cnt == '0) begin
                quotient  <= neg_q ? -q_nx : q_nx;
                remainder <= neg_r ? -r_nx : r_nx;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider_64.sv
// tb_seq_divider_64: directed scoreboard bench for seq_divider_64
module tb_seq_divider_64;
    localparam int W = 64;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, is_signed = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, div_by_zero;
    logic [W-1:0] dividend = '0, divisor = '0, quotient, remainder;
    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } res_t;
    res_t sb[$];
    int checks = 0, failures = 0;

    seq_divider_64 #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
        .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result built from magnitudes and RISC-V sign/zero rules.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        res_t e;
        logic [W-1:0] am, bm;
        if (b == '0) begin
            e.q = '1; e.r = a; e.z = 1'b1;
        end else begin
            am = (s && a[W-1]) ? -a : a;
            bm = (s && b[W-1]) ? -b : b;
            e.q = am / bm;
            e.r = am % bm;
            if (s && (a[W-1] ^ b[W-1])) e.q = -e.q;
            if (s && a[W-1]) e.r = -e.r;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit push);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_ready", in_ready, 1);
        in_valid = 1'b1; dividend = a; divisor = b; is_signed = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom}; is_signed = $urandom_range(1);
        if (push) sb.push_back(model(a, b, s));
    endtask

    task automatic wait_result(input int exp_lat, input int hold, input bit noise);
        int n = 0;
        bit busy_ok = 1'b1;
        res_t e;
        while (out_valid !== 1'b1 && n < 200) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            if (noise) begin
                in_valid = 1'b1; dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
            end
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
        chk("out_valid_rise", out_valid, 1);
        chk("latency", n, exp_lat);
        chk("busy_in_ready_low", busy_ok, 1);
        chk("sb_depth", sb.size(), 1);
        e = '{q: '0, r: '0, z: 1'b0};
        if (sb.size() > 0) e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.z);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_quotient", quotient, e.q);
            chk("hold_remainder", remainder, e.r);
            chk("hold_dbz", div_by_zero, e.z);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] a, b;
        int n;
        bit quiet;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);

        start_op(64'd100, 64'd7, 1'b0, 1'b1);
        wait_result(W, 0, 1'b1);
        chk("q_100_7", quotient, 64'd14);

        start_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1);
        wait_result(W, 0, 1'b0);
        chk("q_m7_2", quotient, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("r_m7_2", remainder, 64'hFFFF_FFFF_FFFF_FFFF);

        start_op(64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1);
        wait_result(W, 0, 1'b0);
        chk("q_7_m2", quotient, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("r_7_m2", remainder, 64'd1);

        start_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        sb.push_back('{q: 64'h8000_0000_0000_0000, r: '0, z: 1'b0});
        wait_result(W, 0, 1'b0);

        start_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        wait_result(W, 0, 1'b0);
        chk("r_ovf_unsigned", remainder, 64'h8000_0000_0000_0000);

        start_op(64'h1234, 64'd0, 1'b1, 1'b1);
        wait_result(0, 0, 1'b0);
        chk("dbz_q", quotient, 64'hFFFF_FFFF_FFFF_FFFF);

        start_op(64'hFFFF_FFFF_FFFF_FF00, 64'd0, 1'b1, 1'b1);
        wait_result(0, 2, 1'b0);

        start_op(64'd100, 64'd7, 1'b0, 1'b1);
        wait_result(W, 10, 1'b0);
        start_op(64'd15, 64'd4, 1'b0, 1'b1);
        wait_result(W, 0, 1'b0);
        chk("q_15_4", quotient, 64'd3);
        chk("r_15_4", remainder, 64'd3);

        start_op(64'd1000, 64'd3, 1'b0, 1'b0);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_quiet", quiet, 1);
        start_op(64'd9, 64'd3, 1'b0, 1'b1);
        wait_result(W, 0, 1'b0);
        chk("q_9_3", quotient, 64'd3);
        chk("r_9_3", remainder, 64'd0);

        for (int i = 0; i < 6; i++) begin
            a = {$urandom, $urandom};
            b = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : {$urandom, $urandom};
            if (i == 5) b = -b;
            start_op(a, b, i[0], 1'b1);
            wait_result(W, 0, 1'b0);
        end

        n = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) n++;
        end
        chk("no_stale_output", n, 0);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
